// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and helpers for the raster generator.
// Two mode sets are kept: 640x480@60 (default, active-low syncs) and 800x600@60.
package vga_timing_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam logic DEF_HS_POL = 1'b0;
   localparam logic DEF_VS_POL = 1'b0;

   // 800x600 needs an 11-bit counter, since its horizontal total exceeds 1024.
   localparam int SVGA_H_ACTIVE = 800;
   localparam int SVGA_H_FP     = 40;
   localparam int SVGA_H_SYNC   = 128;
   localparam int SVGA_H_BP     = 88;
   localparam int SVGA_V_ACTIVE = 600;
   localparam int SVGA_V_FP     = 1;
   localparam int SVGA_V_SYNC   = 4;
   localparam int SVGA_V_BP     = 23;
   localparam logic SVGA_HS_POL = 1'b1;
   localparam logic SVGA_VS_POL = 1'b1;

   function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrap counter plus decode of the active and sync regions.
// Region decode is done one bit wider so region ends equal to 2^W still compare correctly.
module vga_axis_counter #(
   parameter int TOTAL  = 800,
   parameter int ACTIVE = 640,
   parameter int FP     = 16,
   parameter int SYNC   = 96,
   parameter int W      = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ce,
   output logic [W-1:0] count,
   output logic         wrap,
   output logic         in_active,
   output logic         in_sync
);

   localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
   localparam logic [W:0]   ACTIVE_END = (W+1)'(ACTIVE);
   localparam logic [W:0]   SYNC_START = (W+1)'(ACTIVE + FP);
   localparam logic [W:0]   SYNC_END   = (W+1)'(ACTIVE + FP + SYNC);

   logic [W:0] count_ext;

   assign count_ext = {1'b0, count};
   assign wrap      = ce && (count == LAST);
   assign in_active = count_ext < ACTIVE_END;
   assign in_sync   = (count_ext >= SYNC_START) && (count_ext < SYNC_END);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (ce) begin
         count <= wrap ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with registered syncs, data enable,
// line/frame strobes and RGB blanking; outputs lag hcount/vcount by one pixel.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   COLOR_W  = 4,
   parameter int   CNT_W    = 10,
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter logic HS_POL   = DEF_HS_POL,
   parameter logic VS_POL   = DEF_VS_POL
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pix_ce,
   input  logic [COLOR_W-1:0] red_in,
   input  logic [COLOR_W-1:0] green_in,
   input  logic [COLOR_W-1:0] blue_in,
   output logic [CNT_W-1:0]   hcount,
   output logic [CNT_W-1:0]   vcount,
   output logic [COLOR_W-1:0] red_out,
   output logic [COLOR_W-1:0] green_out,
   output logic [COLOR_W-1:0] blue_out,
   output logic               hsync,
   output logic               vsync,
   output logic               de,
   output logic               line_start,
   output logic               frame_start
);

   localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   logic h_wrap, h_active, h_sync;
   logic v_wrap_unused, v_active, v_sync;
   logic pix_de;

   vga_axis_counter #(
      .TOTAL (H_TOTAL),
      .ACTIVE(H_ACTIVE),
      .FP    (H_FP),
      .SYNC  (H_SYNC),
      .W     (CNT_W)
   ) u_h_axis (
      .clk      (clk),
      .rst      (rst),
      .ce       (pix_ce),
      .count    (hcount),
      .wrap     (h_wrap),
      .in_active(h_active),
      .in_sync  (h_sync)
   );

   // The vertical axis only moves when the horizontal axis wraps.
   vga_axis_counter #(
      .TOTAL (V_TOTAL),
      .ACTIVE(V_ACTIVE),
      .FP    (V_FP),
      .SYNC  (V_SYNC),
      .W     (CNT_W)
   ) u_v_axis (
      .clk      (clk),
      .rst      (rst),
      .ce       (h_wrap),
      .count    (vcount),
      .wrap     (v_wrap_unused),
      .in_active(v_active),
      .in_sync  (v_sync)
   );

   assign pix_de = h_active && v_active;

   // Strobes drop on idle pixel-enable cycles so each lasts exactly one clk.
   always_ff @(posedge clk) begin
      if (rst) begin
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         de          <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         red_out     <= '0;
         green_out   <= '0;
         blue_out    <= '0;
      end else if (pix_ce) begin
         hsync       <= h_sync ? HS_POL : ~HS_POL;
         vsync       <= v_sync ? VS_POL : ~VS_POL;
         de          <= pix_de;
         line_start  <= (hcount == '0);
         frame_start <= (hcount == '0) && (vcount == '0);
         red_out     <= pix_de ? red_in   : '0;
         green_out   <= pix_de ? green_in : '0;
         blue_out    <= pix_de ? blue_in  : '0;
      end else begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a 640-wide active-low instance and an 800x600-timed
// active-high instance, both with short vertical totals, checked against a pixel-index model.
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

   localparam int A_HT = 800;
   localparam int A_VT = 8;
   localparam int B_HT = 1056;
   localparam int B_VT = 7;

   logic        clk = 1'b0;
   logic        rst;
   logic        pix_ce;
   logic [3:0]  red_in, green_in, blue_in;

   logic [9:0]  a_hcount, a_vcount;
   logic [3:0]  a_red, a_green, a_blue;
   logic        a_hsync, a_vsync, a_de, a_line_start, a_frame_start;
   logic [10:0] b_hcount, b_vcount;
   logic [3:0]  b_red, b_green, b_blue;
   logic        b_hsync, b_vsync, b_de, b_line_start, b_frame_start;

   int          checks = 0;
   int          passes = 0;
   bit          checking = 1'b0;
   bit          vary_rgb = 1'b0;
   logic [11:0] rgb_seq = 12'h000;

   int          idx_a, idx_b;
   logic [16:0] exp_a, exp_b;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .COLOR_W(4), .CNT_W(10),
      .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0)
   ) dut_a (
      .clk(clk), .rst(rst), .pix_ce(pix_ce),
      .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
      .hcount(a_hcount), .vcount(a_vcount),
      .red_out(a_red), .green_out(a_green), .blue_out(a_blue),
      .hsync(a_hsync), .vsync(a_vsync), .de(a_de),
      .line_start(a_line_start), .frame_start(a_frame_start)
   );

   vga_timing_gen #(
      .COLOR_W(4), .CNT_W(11),
      .H_ACTIVE(SVGA_H_ACTIVE), .H_FP(SVGA_H_FP), .H_SYNC(SVGA_H_SYNC), .H_BP(SVGA_H_BP),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(SVGA_HS_POL), .VS_POL(SVGA_VS_POL)
   ) dut_b (
      .clk(clk), .rst(rst), .pix_ce(pix_ce),
      .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
      .hcount(b_hcount), .vcount(b_vcount),
      .red_out(b_red), .green_out(b_green), .blue_out(b_blue),
      .hsync(b_hsync), .vsync(b_vsync), .de(b_de),
      .line_start(b_line_start), .frame_start(b_frame_start)
   );

   // Expected registered outputs for linear pixel index p: {de, hsync, vsync, line, frame, rgb}.
   function automatic logic [16:0] pixelOut(input int p, input int ha, input int hf, input int hs,
                                            input int hb, input int va, input int vf, input int vs,
                                            input logic hpol, input logic vpol, input logic [11:0] rgb);
      int   ht, h, v;
      logic d, hsa, vsa;
      ht  = ha + hf + hs + hb;
      h   = p % ht;
      v   = p / ht;
      d   = (h < ha) && (v < va);
      hsa = (h >= ha + hf) && (h < ha + hf + hs);
      vsa = (v >= va + vf) && (v < va + vf + vs);
      return {d, hsa ? hpol : ~hpol, vsa ? vpol : ~vpol, h == 0, p == 0, d ? rgb : 12'h000};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         idx_a <= 0;
         idx_b <= 0;
         exp_a <= {1'b0, 1'b1, 1'b1, 14'h0};
         exp_b <= {1'b0, 1'b0, 1'b0, 14'h0};
      end else if (pix_ce) begin
         exp_a <= pixelOut(idx_a, 640, 16, 96, 48, 4, 1, 2, 1'b0, 1'b0, {red_in, green_in, blue_in});
         exp_b <= pixelOut(idx_b, 800, 40, 128, 88, 3, 1, 2, 1'b1, 1'b1, {red_in, green_in, blue_in});
         idx_a <= (idx_a + 1) % (A_HT * A_VT);
         idx_b <= (idx_b + 1) % (B_HT * B_VT);
      end else begin
         exp_a[13:12] <= 2'b00;
         exp_b[13:12] <= 2'b00;
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
   endtask

   task automatic applyStimulus(input logic r, input logic ce);
      @(negedge clk);
      rst    = r;
      pix_ce = ce;
      if (vary_rgb) begin
         rgb_seq = rgb_seq + 12'h137;
         {red_in, green_in, blue_in} = rgb_seq;
      end else begin
         {red_in, green_in, blue_in} = 12'hF5A;
      end
   endtask

   always @(negedge clk) begin
      if (checking) begin
         checkOutput("a_cycle",
            {27'h0, a_hcount, a_vcount, a_de, a_hsync, a_vsync, a_line_start, a_frame_start, a_red, a_green, a_blue},
            {27'h0, 10'(idx_a % A_HT), 10'(idx_a / A_HT), exp_a});
         checkOutput("b_cycle",
            {25'h0, b_hcount, b_vcount, b_de, b_hsync, b_vsync, b_line_start, b_frame_start, b_red, b_green, b_blue},
            {25'h0, 11'(idx_b % B_HT), 11'(idx_b / B_HT), exp_b});
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int a_hs_low = 0, a_hs_first_h = -1, a_vs_low = 0, a_de_cnt = 0, a_fs_cnt = 0;
      int a_ls_first = -1, a_ls_second = -1, col_bad = 0;
      int b_hs_high = 0, b_hs_first_h = -1, b_vs_high = 0, b_vs_first = -1, b_fs_cnt = 0;
      int ls_cnt = 0, ls_first = -1, ls_second = -1, ls_double = 0;
      bit prev_ls;
      bit found;

      rst = 1'b1;
      pix_ce = 1'b1;
      {red_in, green_in, blue_in} = 12'hF5A;

      // Phase 1: free-running pixel enable, constant colour.
      repeat (3) applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      checkOutput("a_reset_counts", {a_hcount, a_vcount}, 20'h0);
      checkOutput("a_reset_ctrl", {a_de, a_hsync, a_vsync, a_line_start, a_frame_start}, 5'b01100);
      checkOutput("a_reset_rgb", {a_red, a_green, a_blue}, 12'h000);
      checkOutput("b_reset_ctrl", {b_de, b_hsync, b_vsync, b_line_start, b_frame_start}, 5'b00000);
      checking = 1'b1;

      for (int k = 0; k < B_HT * B_VT; k++) begin
         applyStimulus(1'b0, 1'b1);
         if (k < A_HT && !a_hsync) begin
            if (a_hs_first_h < 0) a_hs_first_h = int'(a_hcount);
            a_hs_low++;
         end
         if (k < A_HT * A_VT) begin
            a_vs_low += int'(!a_vsync);
            a_de_cnt += int'(a_de);
            a_fs_cnt += int'(a_frame_start);
            if (a_line_start) begin
               if (a_ls_first < 0) a_ls_first = k;
               else if (a_ls_second < 0) a_ls_second = k;
            end
            if (a_de && {a_red, a_green, a_blue} != 12'hF5A) col_bad++;
            if (!a_de && {a_red, a_green, a_blue} != 12'h000) col_bad++;
         end
         if (k == A_HT * A_VT - 1) checkOutput("a_frame_wrap", {a_hcount, a_vcount}, 20'h0);
         if (k < B_HT && b_hsync) begin
            if (b_hs_first_h < 0) b_hs_first_h = int'(b_hcount);
            b_hs_high++;
         end
         if (b_vsync) begin
            if (b_vs_first < 0) b_vs_first = int'({b_vcount, b_hcount});
            b_vs_high++;
         end
         b_fs_cnt += int'(b_frame_start);
         if (k == B_HT * B_VT - 1) checkOutput("b_frame_wrap", {b_hcount, b_vcount}, 22'h0);
      end
      checkOutput("a_hsync_low_clks", a_hs_low, 96);
      checkOutput("a_hsync_first_low_hcount", a_hs_first_h, 657);
      checkOutput("a_line_period", a_ls_second - a_ls_first, 800);
      checkOutput("a_vsync_low_clks", a_vs_low, 1600);
      checkOutput("a_de_clks", a_de_cnt, 2560);
      checkOutput("a_frame_start_count", a_fs_cnt, 1);
      checkOutput("a_blanking_errors", col_bad, 0);
      checkOutput("b_hsync_high_clks", b_hs_high, 128);
      checkOutput("b_hsync_first_high_hcount", b_hs_first_h, 841);
      checkOutput("b_vsync_high_clks", b_vs_high, 2112);
      checkOutput("b_vsync_first_pos", b_vs_first, (4 << 11) | 1);
      checkOutput("b_frame_start_count", b_fs_cnt, 1);

      // Phase 2: pixel enable toggling every clk, varying colour.
      vary_rgb = 1'b1;
      repeat (3) applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      prev_ls = 1'b0;
      for (int k = 0; k < 3200; k++) begin
         applyStimulus(1'b0, (k % 2) == 1);
         if (a_line_start) begin
            ls_cnt++;
            if (ls_first < 0) ls_first = k;
            else if (ls_second < 0) ls_second = k;
            if (prev_ls) ls_double++;
         end
         prev_ls = a_line_start;
      end
      checkOutput("ce_half_line_period", ls_second - ls_first, 1600);
      checkOutput("ce_half_line_start_count", ls_cnt, 2);
      checkOutput("ce_half_line_start_wide", ls_double, 0);

      // Phase 3: one-clk reset in the middle of a frame.
      repeat (3) applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 5000 && !found; i++) begin
         applyStimulus(1'b0, 1'b1);
         if (a_hcount == 10'd300 && a_vcount == 10'd2) found = 1'b1;
      end
      checkOutput("a_reach_300_2", found, 1);
      if (found) begin
         checkOutput("a_de_before_reset", a_de, 1);
         rst = 1'b1;
         applyStimulus(1'b0, 1'b1);
         checkOutput("mid_reset_counts", {a_hcount, a_vcount}, 20'h0);
         checkOutput("mid_reset_ctrl", {a_de, a_hsync, a_vsync, a_line_start, a_frame_start}, 5'b01100);
         checkOutput("mid_reset_rgb", {a_red, a_green, a_blue}, 12'h000);
         applyStimulus(1'b0, 1'b1);
         checkOutput("after_reset_strobes", {a_line_start, a_frame_start, a_hcount}, {2'b11, 10'd1});
      end

      checking = 1'b0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
